issue_queue: RTL

Out-of-order issue queue that sits directly downstream of the rename stage. It accepts one renamed instruction per cycle and holds it until both source physical registers are ready. It then issues the oldest ready instruction to the execute stage through a valid/ready handshake. Source readiness is updated by a writeback broadcast, and a branch mispredict flushes the whole queue.

---
 rtl/issue_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// issue_queue: compacting out-of-order issue queue with oldest-ready select, writeback wakeup and flush
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_rd_valid,
    input  logic [PREG_W-1:0]       in_rd_idx,
    input  logic                    in_rs1_valid,
    input  logic [PREG_W-1:0]       in_rs1_idx,
    input  logic                    in_rs1_ready,
    input  logic                    in_rs2_valid,
    input  logic [PREG_W-1:0]       in_rs2_idx,
    input  logic                    in_rs2_ready,
    input  logic                    in_is_branch,
    input  logic                    wb_valid,
    input  logic [PREG_W-1:0]       wb_idx,
    input  logic                    br_valid,
    input  logic                    br_hit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_rd_valid,
    output logic [PREG_W-1:0]       out_rd_idx,
    output logic                    out_rs1_valid,
    output logic [PREG_W-1:0]       out_rs1_idx,
    output logic                    out_rs2_valid,
    output logic [PREG_W-1:0]       out_rs2_idx,
    output logic                    out_is_branch,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic              v;
        logic              rdv;
        logic [PREG_W-1:0] rd;
        logic              s1v;
        logic [PREG_W-1:0] s1;
        logic              r1;
        logic              s2v;
        logic [PREG_W-1:0] s2;
        logic              r2;
        logic              br;
    } entry_t;

    entry_t        q     [DEPTH];
    entry_t        woken [DEPTH];
    entry_t        nq    [DEPTH];
    entry_t        ent_in;
    logic [AW-1:0] sel;
    logic [CW-1:0] wr;
    logic          found, issue, accept, flush;

    assign flush    = br_valid & ~br_hit;
    assign in_ready = count < CW'(DEPTH);
    assign accept   = in_valid & in_ready;
    assign issue    = found & out_ready;
    assign wr       = count - CW'(issue);

    // invalid operands are stored ready; a same-cycle writeback wakes the incoming entry too
    assign ent_in = '{
        v:   1'b1,
        rdv: in_rd_valid,
        rd:  in_rd_idx,
        s1v: in_rs1_valid,
        s1:  in_rs1_idx,
        r1:  ~in_rs1_valid | in_rs1_ready | (wb_valid & (wb_idx == in_rs1_idx)),
        s2v: in_rs2_valid,
        s2:  in_rs2_idx,
        r2:  ~in_rs2_valid | in_rs2_ready | (wb_valid & (wb_idx == in_rs2_idx)),
        br:  in_is_branch
    };

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (q[i].v && q[i].r1 && q[i].r2) begin
                found = 1'b1;
                sel   = AW'(i);
            end
    end

    assign out_valid     = found;
    assign out_rd_valid  = found & q[sel].rdv;
    assign out_rd_idx    = found ? q[sel].rd : '0;
    assign out_rs1_valid = found & q[sel].s1v;
    assign out_rs1_idx   = found ? q[sel].s1 : '0;
    assign out_rs2_valid = found & q[sel].s2v;
    assign out_rs2_idx   = found ? q[sel].s2 : '0;
    assign out_is_branch = found & q[sel].br;

    // wakeup, then close the gap left by the issued slot, then append at the new tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]    = q[i];
            woken[i].r1 = q[i].r1 | (wb_valid & q[i].s1v & (q[i].s1 == wb_idx));
            woken[i].r2 = q[i].r2 | (wb_valid & q[i].s2v & (q[i].s2 == wb_idx));
        end
        nq = woken;
        for (int i = 0; i < DEPTH - 1; i++)
            if (issue && AW'(i) >= sel) nq[i] = woken[i+1];
        if (issue) nq[DEPTH-1] = '0;
        if (accept) nq[wr[AW-1:0]] = ent_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '{default: '0};
            count <= '0;
        end else if (flush) begin
            q     <= '{default: '0};
            count <= '0;
        end else begin
            q     <= nq;
            count <= count + CW'(accept) - CW'(issue);
        end
    end
endmodule
